rtc_sync_ctrl: RTL and testbench
================================

# rtc_sync_ctrl

Sequencing and arbitration controller in front of the RTC seconds counter. Collects time-set requests from two requesters, the host link (decoded UART time frame) and the manual-set front panel. Range-checks each request and drives the counter's `synced`/`hour_in`/`min_in`/`sec_in` load port with a clean single-cycle rising edge. Schedules periodic host resynchronisation with timeout, bounded retry and a stale-time status flag.

## Interface
Parameters:
- `CLK_FREQ`, 50000000: clk cycles per second; sets the internal 1 s prescaler.
- `RESYNC_SEC`, 3600: seconds between automatic host sync requests.
- `TIMEOUT_SEC`, 2: seconds to wait for a host reply per request.
- `MAX_RETRY`, 3: extra requests issued after the first times out.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `host_valid` in 1: host time frame available.
- `host_hour` in 5, `host_min` in 6, `host_sec` in 6: host time.
- `host_ready` out 1: host frame accepted when `host_valid & host_ready`.
- `man_valid` in 1: manual-set request.
- `man_hour` in 5, `man_min` in 6, `man_sec` in 6: manual time.
- `man_ready` out 1: manual handshake ready.
- `sync_req` out 1: one-cycle pulse asking the host to send time.
- `synced` out 1: load strobe to the RTC counter.
- `hour_out` out 5, `min_out` out 6, `sec_out` out 6: load data to the RTC counter.
- `stale` out 1: time not confirmed by the host since reset or since the last exhausted retry sequence.
- `range_err` out 1: one-cycle pulse when an accepted request is out of range.

## Operation
- FSM states: IDLE, REQ, WAIT, LOAD, GAP.
- IDLE: when the resync second counter reaches `RESYNC_SEC`, go to REQ. After reset the counter is preloaded, so REQ is entered on the first cycle after reset release.
- REQ: assert `sync_req` for 1 cycle, clear the timeout counter, go to WAIT.
- WAIT: count seconds.
  - On a host transfer, go to LOAD.
  - At `TIMEOUT_SEC` with retry < `MAX_RETRY`: increment retry, go to REQ.
  - Otherwise (retries exhausted): set `stale`=1, clear retry, restart the resync counter, go to IDLE.
- LOAD: `synced`=1 for exactly 1 cycle, go to GAP.
- GAP: `synced`=0 for 1 cycle, then go to IDLE. This guarantees the counter sees a fresh rising edge on every load.
- Ready signals (combinational):
  - `man_ready` = state ∈ {IDLE, REQ, WAIT}.
  - `host_ready` = state ∈ {IDLE, WAIT} & ~`man_valid`.
  - Manual wins if both are valid in the same cycle; the host frame stays pending.
- Accepted data is registered into `hour_out`/`min_out`/`sec_out` on the transfer cycle.
- Range check: valid iff hour ≤ 23, min ≤ 59, sec ≤ 59, all compared unsigned at full width.
  - Invalid request: still consumed (ready=1), pulse `range_err`, outputs unchanged, no LOAD.
  - State rules for an invalid request: from IDLE or REQ, stay on the normal path. From WAIT, remain in WAIT with the timeout still running.
- A valid host load clears `stale`, clears retry and restarts the resync counter.
- A valid manual load restarts the resync counter only. It does not clear `stale` and does not cancel a pending WAIT; the FSM goes LOAD→GAP→IDLE, and a later host frame is still accepted unsolicited in IDLE.
- Unsolicited host frame accepted in IDLE: treated as a host load.

## Timing
- Reset values: state IDLE, `sync_req` 0, `synced` 0, `hour_out`/`min_out`/`sec_out` 0, `stale` 1, `range_err` 0, retry 0, prescaler 0, resync counter at `RESYNC_SEC`.
- Transfer in cycle N → outputs valid and state LOAD in cycle N+1 (`synced`=1) → GAP in N+2 → IDLE in N+3.
- Output data is held from N+1 until the next valid transfer, so it is stable while `synced` is high and the cycle after.
- Second tick: prescaler wraps at `CLK_FREQ`−1. Second counters advance only on the wrap cycle.
- Timeout window is TIMEOUT_SEC ticks ±1 tick, since the prescaler is free-running.
- `rst` asserted in any state: all registers return to reset values on the next edge. An in-flight `synced` is dropped low immediately.

## Structure
- Shared package `rtc_pkg`:
  - FSM state encoding.
  - Limit constants: `MAX_HOUR`=23, `MAX_MIN`=59, `MAX_SEC`=59.
  - Field widths: 5/6/6.
- One natural sub-module, `sec_prescaler`: counts `CLK_FREQ` cycles and emits a 1-cycle `tick`. It is reusable by other RTC blocks.

## Test plan
Bench settings: `CLK_FREQ`=10, `RESYNC_SEC`=5, `TIMEOUT_SEC`=2, `MAX_RETRY`=1.
- Reset release → `sync_req` pulse in cycle 2. Host replies 12:34:56 in WAIT → `synced` high 1 cycle with outputs 12:34:56; `stale` drops to 0.
- No host reply → second `sync_req` ≈20 cycles after the first → after a further ≈20 cycles `stale`=1, FSM in IDLE, next request ≈50 cycles later.
- `man_valid` and `host_valid` in the same IDLE cycle (07:00:00 vs 08:00:00) → `host_ready`=0, load 07:00:00. Host loads 08:00:00 after GAP, i.e. two distinct `synced` edges.
- Manual 24:00:00 → `range_err` pulse, no `synced`, outputs unchanged. Host 23:59:59 → loaded.
- `rst` asserted during LOAD → `synced`=0 the next cycle, all outputs 0, `stale`=1.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared RTC definitions: time field widths, range limits, controller FSM encoding
// and small helpers used by the RTC sequencing blocks.
package rtc_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_LOAD,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
  } rtc_time_t;

  // Width of a counter that must hold 0..max_val; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic time_in_range(input rtc_time_t t);
    return (t.hour <= MAX_HOUR) && (t.minute <= MAX_MIN) && (t.second <= MAX_SEC);
  endfunction

endpackage

// File: rtl/rtc_sync_ctrl_if.sv
// Requester handshakes (host link, front panel) and the RTC counter load port
// of the sync controller, bundled with controller-side and requester-side views.
interface rtc_sync_ctrl_if;
  import rtc_pkg::*;

  logic              host_valid;
  logic [HOUR_W-1:0] host_hour;
  logic [MIN_W-1:0]  host_min;
  logic [SEC_W-1:0]  host_sec;
  logic              host_ready;

  logic              man_valid;
  logic [HOUR_W-1:0] man_hour;
  logic [MIN_W-1:0]  man_min;
  logic [SEC_W-1:0]  man_sec;
  logic              man_ready;

  logic              sync_req;
  logic              synced;
  logic [HOUR_W-1:0] hour_out;
  logic [MIN_W-1:0]  min_out;
  logic [SEC_W-1:0]  sec_out;
  logic              stale;
  logic              range_err;

  modport slave (
    input  host_valid, host_hour, host_min, host_sec,
    input  man_valid, man_hour, man_min, man_sec,
    output host_ready, man_ready,
    output sync_req, synced, hour_out, min_out, sec_out, stale, range_err
  );

  modport master (
    output host_valid, host_hour, host_min, host_sec,
    output man_valid, man_hour, man_min, man_sec,
    input  host_ready, man_ready,
    input  sync_req, synced, hour_out, min_out, sec_out, stale, range_err
  );

endinterface

// File: rtl/sec_prescaler.sv
// Free-running divider producing a one-cycle tick every CLK_FREQ clocks.
module sec_prescaler
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned     CNT_W    = cnt_width(CLK_FREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_sync_ctrl.sv
// Arbitrates host/manual time-set requests, range-checks them and drives the RTC
// load port with a clean one-cycle strobe; schedules periodic host resync with retry.
module rtc_sync_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned RESYNC_SEC  = 3600,
  parameter int unsigned TIMEOUT_SEC = 2,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic            clk,
  input  logic            rst,
  rtc_sync_ctrl_if.slave  bus
);

  localparam int unsigned      RS_W   = cnt_width(RESYNC_SEC);
  localparam logic [RS_W-1:0]  RS_MAX = RS_W'(RESYNC_SEC);
  localparam int unsigned      TO_W   = cnt_width(TIMEOUT_SEC);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_SEC);
  localparam int unsigned      RT_W   = cnt_width(MAX_RETRY);
  localparam logic [RT_W-1:0]  RT_MAX = RT_W'(MAX_RETRY);

  state_e          state_q, state_d;
  logic [RS_W-1:0] rs_cnt_q, rs_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [RT_W-1:0] retry_q, retry_d;
  logic            stale_q, stale_d;
  logic            range_err_q, range_err_d;
  rtc_time_t       time_q, time_d;

  logic      tick;
  rtc_time_t man_t, host_t, sel_t;
  logic      man_xfer, host_xfer, xfer, in_range, load;
  logic      rs_due, to_done, retry_left, give_up;

  sec_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // FSM outputs: handshake readies and the counter load port
  always_comb begin
    bus.man_ready  = (state_q == ST_IDLE) || (state_q == ST_REQ) || (state_q == ST_WAIT);
    bus.host_ready = ((state_q == ST_IDLE) || (state_q == ST_WAIT)) && !bus.man_valid;
    bus.sync_req   = (state_q == ST_REQ);
    bus.synced     = (state_q == ST_LOAD);
    bus.hour_out   = time_q.hour;
    bus.min_out    = time_q.minute;
    bus.sec_out    = time_q.second;
    bus.stale      = stale_q;
    bus.range_err  = range_err_q;
  end

  // Transfer decode; man_valid already masks host_ready, so the two are exclusive
  always_comb begin
    man_t      = {bus.man_hour, bus.man_min, bus.man_sec};
    host_t     = {bus.host_hour, bus.host_min, bus.host_sec};
    man_xfer   = bus.man_valid && bus.man_ready;
    host_xfer  = bus.host_valid && bus.host_ready;
    xfer       = man_xfer || host_xfer;
    sel_t      = man_xfer ? man_t : host_t;
    in_range   = time_in_range(sel_t);
    load       = xfer && in_range;
    rs_due     = (rs_cnt_q == RS_MAX);
    to_done    = (state_q == ST_WAIT) && (to_cnt_q == TO_MAX);
    retry_left = (retry_q < RT_MAX);
    give_up    = to_done && !load && !retry_left;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load)        state_d = ST_LOAD;
        else if (rs_due) state_d = ST_REQ;
      end
      ST_REQ:  state_d = load ? ST_LOAD : ST_WAIT;
      ST_WAIT: begin
        if (load)         state_d = ST_LOAD;
        else if (to_done) state_d = retry_left ? ST_REQ : ST_IDLE;
      end
      ST_LOAD: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Only a valid host load confirms the time; manual loads just push out the next resync
  always_comb begin
    time_d      = load ? sel_t : time_q;
    range_err_d = xfer && !in_range;

    stale_d = stale_q;
    if (host_xfer && in_range) stale_d = 1'b0;
    else if (give_up)          stale_d = 1'b1;

    retry_d = retry_q;
    if ((host_xfer && in_range) || give_up) retry_d = '0;
    else if (to_done && !load)              retry_d = retry_q + RT_W'(1);

    to_cnt_d = to_cnt_q;
    if (state_q == ST_REQ)                                   to_cnt_d = '0;
    else if ((state_q == ST_WAIT) && tick && !(to_cnt_q == TO_MAX)) to_cnt_d = to_cnt_q + TO_W'(1);

    rs_cnt_d = rs_cnt_q;
    if (load || give_up)    rs_cnt_d = '0;
    else if (tick && !rs_due) rs_cnt_d = rs_cnt_q + RS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_cnt_q    <= RS_MAX;
      to_cnt_q    <= '0;
      retry_q     <= '0;
      stale_q     <= 1'b1;
      range_err_q <= 1'b0;
      time_q      <= '0;
    end else begin
      rs_cnt_q    <= rs_cnt_d;
      to_cnt_q    <= to_cnt_d;
      retry_q     <= retry_d;
      stale_q     <= stale_d;
      range_err_q <= range_err_d;
      time_q      <= time_d;
    end
  end

endmodule

// File: tb/tb_rtc_sync_ctrl.sv
// Scenario bench for rtc_sync_ctrl: expected loads are queued when driven and
// compared by a monitor whenever the load strobe is seen.
module tb_rtc_sync_ctrl;
  import rtc_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_synced = 0;
  logic prev_synced = 1'b0;
  rtc_time_t exp_q[$];

  rtc_sync_ctrl_if bus();

  rtc_sync_ctrl #(
    .CLK_FREQ    (10),
    .RESYNC_SEC  (5),
    .TIMEOUT_SEC (2),
    .MAX_RETRY   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rtc_time_t mk(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    return {h, m, s};
  endfunction

  // Scoreboard monitor: every strobe must be a fresh edge carrying the next queued time
  always @(negedge clk) begin
    if (bus.synced === 1'b1) begin
      rtc_time_t got, exp;
      got = {bus.hour_out, bus.min_out, bus.sec_out};
      n_checks++;
      if (prev_synced === 1'b1)
        $display("FAIL synced_width: synced high two cycles, required one");
      else if (exp_q.size() == 0)
        $display("FAIL unexpected_load: got %0d:%0d:%0d with no load expected",
                 got.hour, got.minute, got.second);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp)
          $display("FAIL load_data: got %0d:%0d:%0d required %0d:%0d:%0d",
                   got.hour, got.minute, got.second, exp.hour, exp.minute, exp.second);
        else n_pass++;
      end
      if (prev_synced !== 1'b1) n_synced++;
    end
    prev_synced = bus.synced;
  end

  task automatic set_man(input logic v, input rtc_time_t t);
    bus.man_valid = v;
    {bus.man_hour, bus.man_min, bus.man_sec} = t;
  endtask

  task automatic set_host(input logic v, input rtc_time_t t);
    bus.host_valid = v;
    {bus.host_hour, bus.host_min, bus.host_sec} = t;
  endtask

  task automatic wait_sync_req(input int max_cyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (bus.sync_req === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_stale(input int max_cyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (bus.stale === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_man(1'b0, '0);
    set_host(1'b0, '0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.synced, bus.sync_req, bus.range_err, bus.stale} !== 4'b0001)
      $display("FAIL reset_flags: synced/sync_req/range_err/stale got %b required 0001",
               {bus.synced, bus.sync_req, bus.range_err, bus.stale});
    else n_pass++;
    n_checks++;
    if ({bus.hour_out, bus.min_out, bus.sec_out} !== 17'd0)
      $display("FAIL reset_time: got %0d:%0d:%0d required 0:0:0", bus.hour_out, bus.min_out, bus.sec_out);
    else n_pass++;
    n_checks++;
    if ({bus.man_ready, bus.host_ready} !== 2'b11)
      $display("FAIL reset_ready: got %b required 11", {bus.man_ready, bus.host_ready});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.sync_req !== 1'b1) $display("FAIL first_sync_req: got %b required 1", bus.sync_req);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.sync_req, bus.host_ready} !== 2'b01)
      $display("FAIL sync_req_pulse: sync_req/host_ready got %b required 01", {bus.sync_req, bus.host_ready});
    else n_pass++;
  endtask

  task automatic test_host_load();
    set_host(1'b1, mk(5'd12, 6'd34, 6'd56));
    exp_q.push_back(mk(5'd12, 6'd34, 6'd56));
    #1;
    n_checks++;
    if (bus.host_ready !== 1'b1) $display("FAIL host_ready_wait: got %b required 1", bus.host_ready);
    else n_pass++;
    @(negedge clk);
    set_host(1'b0, '0);
    n_checks++;
    if ({bus.synced, bus.stale} !== 2'b10)
      $display("FAIL host_load: synced/stale got %b required 10", {bus.synced, bus.stale});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.synced, bus.man_ready, bus.hour_out} !== {2'b00, 5'd12})
      $display("FAIL gap_cycle: synced/man_ready/hour got %b/%b/%0d required 0/0/12",
               bus.synced, bus.man_ready, bus.hour_out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.man_ready !== 1'b1 || exp_q.size() != 0)
      $display("FAIL back_to_idle: man_ready %b pending %0d required 1 and 0", bus.man_ready, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc;
    bit seen;
    wait_sync_req(80, cyc, seen);
    n_checks++;
    if (!seen || cyc < 35 || cyc > 56)
      $display("FAIL resync_period: seen %b after %0d cycles required 35..56", seen, cyc);
    else n_pass++;
    wait_sync_req(40, cyc, seen);
    n_checks++;
    if (!seen || cyc < 10 || cyc > 25)
      $display("FAIL retry_req: seen %b after %0d cycles required 10..25", seen, cyc);
    else n_pass++;
    wait_stale(40, cyc, seen);
    n_checks++;
    if (!seen || cyc < 10 || cyc > 25 || bus.sync_req !== 1'b0)
      $display("FAIL exhausted: stale seen %b after %0d cycles sync_req %b required 10..25 and 0",
               seen, cyc, bus.sync_req);
    else n_pass++;
    wait_sync_req(80, cyc, seen);
    n_checks++;
    if (!seen || cyc < 38 || cyc > 56 || bus.stale !== 1'b1)
      $display("FAIL post_exhaust_req: seen %b after %0d cycles stale %b required 38..56 and 1",
               seen, cyc, bus.stale);
    else n_pass++;
    @(negedge clk);
    set_host(1'b1, mk(5'd1, 6'd2, 6'd3));
    exp_q.push_back(mk(5'd1, 6'd2, 6'd3));
    @(negedge clk);
    set_host(1'b0, '0);
    n_checks++;
    if ({bus.synced, bus.stale} !== 2'b10)
      $display("FAIL recover: synced/stale got %b required 10", {bus.synced, bus.stale});
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arbitration();
    int base;
    base = n_synced;
    set_man(1'b1, mk(5'd7, 6'd0, 6'd0));
    set_host(1'b1, mk(5'd8, 6'd0, 6'd0));
    exp_q.push_back(mk(5'd7, 6'd0, 6'd0));
    exp_q.push_back(mk(5'd8, 6'd0, 6'd0));
    #1;
    n_checks++;
    if ({bus.man_ready, bus.host_ready} !== 2'b10)
      $display("FAIL arb_ready: man/host ready got %b required 10", {bus.man_ready, bus.host_ready});
    else n_pass++;
    @(negedge clk);
    set_man(1'b0, '0);
    n_checks++;
    if ({bus.synced, bus.host_ready} !== 2'b10)
      $display("FAIL arb_load: synced/host_ready got %b required 10", {bus.synced, bus.host_ready});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.synced, bus.host_ready} !== 2'b00)
      $display("FAIL arb_gap: synced/host_ready got %b required 00", {bus.synced, bus.host_ready});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.host_ready !== 1'b1) $display("FAIL arb_host_pending: host_ready got %b required 1", bus.host_ready);
    else n_pass++;
    @(negedge clk);
    set_host(1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (n_synced - base != 2 || exp_q.size() != 0)
      $display("FAIL arb_edges: got %0d loads %0d pending required 2 and 0", n_synced - base, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_range();
    rtc_time_t bad[4];
    bad[0] = mk(5'd24, 6'd0, 6'd0);
    bad[1] = mk(5'd0, 6'd60, 6'd0);
    bad[2] = mk(5'd0, 6'd0, 6'd60);
    bad[3] = mk(5'd31, 6'd63, 6'd63);
    for (int i = 0; i < 4; i++) begin
      set_man(1'b1, bad[i]);
      @(negedge clk);
      set_man(1'b0, '0);
      n_checks++;
      if ({bus.range_err, bus.synced} !== 2'b10 ||
          {bus.hour_out, bus.min_out, bus.sec_out} !== mk(5'd8, 6'd0, 6'd0))
        $display("FAIL range_reject[%0d]: range_err/synced %b time %0d:%0d:%0d required 10 and 8:0:0",
                 i, {bus.range_err, bus.synced}, bus.hour_out, bus.min_out, bus.sec_out);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({bus.range_err, bus.synced} !== 2'b00)
        $display("FAIL range_pulse[%0d]: range_err/synced got %b required 00", i, {bus.range_err, bus.synced});
      else n_pass++;
    end
    set_host(1'b1, mk(5'd23, 6'd59, 6'd59));
    exp_q.push_back(mk(5'd23, 6'd59, 6'd59));
    @(negedge clk);
    set_host(1'b0, '0);
    n_checks++;
    if ({bus.synced, bus.range_err} !== 2'b10)
      $display("FAIL range_max_ok: synced/range_err got %b required 10", {bus.synced, bus.range_err});
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_load();
    set_host(1'b1, mk(5'd5, 6'd6, 6'd7));
    exp_q.push_back(mk(5'd5, 6'd6, 6'd7));
    @(negedge clk);
    set_host(1'b0, '0);
    n_checks++;
    if (bus.synced !== 1'b1) $display("FAIL rst_pre_load: synced got %b required 1", bus.synced);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.synced, bus.sync_req, bus.range_err, bus.stale, bus.hour_out, bus.min_out, bus.sec_out}
        !== {4'b0001, 17'd0})
      $display("FAIL rst_in_load: flags %b time %0d:%0d:%0d required 0001 and 0:0:0",
               {bus.synced, bus.sync_req, bus.range_err, bus.stale}, bus.hour_out, bus.min_out, bus.sec_out);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.sync_req !== 1'b1 || exp_q.size() != 0)
      $display("FAIL rst_restart: sync_req %b pending %0d required 1 and 0", bus.sync_req, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_host_load();
    test_timeout();
    test_arbitration();
    test_range();
    test_reset_in_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
